// File: rtl/alu_issue_wb.sv
// alu_issue_wb: serial operand-issue and writeback sequencer around a combinational 8-bit ALU
module alu_issue_wb #(
  parameter int REGS = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [1:0]   in_dst,
  input  logic [1:0]   in_srca,
  input  logic [1:0]   in_srcb,
  input  logic [W-1:0] in_imm,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_n,
  input  logic [W-1:0] alu_r,
  input  logic [3:0]   alu_cc,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic [1:0]   res_dst,
  output logic [3:0]   flags,
  input  logic [1:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;
  state_t state_q, state_d;
  logic [W-1:0] regs_q [REGS];
  logic [W-1:0] regs_d [REGS];
  logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
  logic [2:0] alu_n_q, alu_n_d, op_q, op_d;
  logic [1:0] dst_q, dst_d, res_dst_q, res_dst_d;
  logic [3:0] flags_q, flags_d;
  logic res_valid_q, res_valid_d;
  always_comb begin
    state_d = state_q;
    regs_d = regs_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_n_d = alu_n_q;
    op_d = op_q;
    dst_d = dst_q;
    res_data_d = res_data_q;
    res_dst_d = res_dst_q;
    flags_d = flags_q;
    res_valid_d = 1'b0;
    if (state_q == IDLE && in_valid) begin
      state_d = ISSUE;
      op_d = in_op;
      dst_d = in_dst;
      alu_a_d = regs_q[in_srca];
      alu_b_d = in_op == 3'd6 ? in_imm : regs_q[in_srcb];
      alu_n_d = (in_op == 3'd6 || in_op == 3'd7) ? 3'd5 : in_op;
    end else if (state_q == ISSUE) begin
      state_d = WB;
    end else if (state_q == WB) begin
      state_d = IDLE;
      // NOP rides through the pipeline but never commits
      if (op_q != 3'd7) begin
        regs_d[dst_q] = alu_r;
        flags_d = alu_cc;
        res_data_d = alu_r;
        res_dst_d = dst_q;
        res_valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      regs_q <= '{default: '0};
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_n_q <= '0;
      op_q <= '0;
      dst_q <= '0;
      res_data_q <= '0;
      res_dst_q <= '0;
      flags_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q <= regs_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_n_q <= alu_n_d;
      op_q <= op_d;
      dst_q <= dst_d;
      res_data_q <= res_data_d;
      res_dst_q <= res_dst_d;
      flags_q <= flags_d;
      res_valid_q <= res_valid_d;
    end
  end
  assign in_ready = state_q == IDLE && !rst;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_n = alu_n_q;
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign res_dst = res_dst_q;
  assign flags = flags_q;
  assign dbg_data = regs_q[dbg_sel];
endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: randomized check of alu_issue_wb against an instruction-level register-file model
module tb_alu_issue_wb;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, res_valid;
  logic [2:0] in_op, alu_n;
  logic [1:0] in_dst, in_srca, in_srcb, res_dst, dbg_sel;
  logic [7:0] in_imm, alu_a, alu_b, alu_r, res_data, dbg_data;
  logic [3:0] alu_cc, flags;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rm [4];
  logic [3:0] fm;
  logic [7:0] rdm;
  logic [1:0] rdst;

  alu_issue_wb dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_dst(in_dst), .in_srca(in_srca), .in_srcb(in_srcb), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_n(alu_n), .alu_r(alu_r), .alu_cc(alu_cc),
    .res_valid(res_valid), .res_data(res_data), .res_dst(res_dst), .flags(flags),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] cc_of(input logic [7:0] r, input logic [7:0] a, input logic [7:0] b);
    return {r == 8'h00, r[7], a[0] ^ b[0], ^r};
  endfunction

  always_comb begin
    case (alu_n)
      3'd0: alu_r = alu_a + alu_b;
      3'd1: alu_r = alu_a - alu_b;
      3'd2: alu_r = {alu_a[6:0], 1'b0};
      3'd3: alu_r = {1'b0, alu_a[7:1]};
      3'd4: alu_r = alu_a;
      default: alu_r = alu_b;
    endcase
    alu_cc = cc_of(alu_r, alu_a, alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_regs();
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk("dbg_reg", dbg_data, rm[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rm[i] = 8'h00;
    fm = 4'h0;
    rdm = 8'h00;
    rdst = 2'd0;
  endtask

  task automatic scramble(input bit hold);
    in_op = 3'($urandom);
    in_dst = 2'($urandom);
    in_srca = 2'($urandom);
    in_srcb = 2'($urandom);
    in_imm = 8'($urandom);
    in_valid = hold ? 1'b1 : 1'($urandom);
  endtask

  // called at a falling edge while idle; returns at the falling edge of the result cycle
  task automatic run(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [7:0] imm, input bit hold);
    logic [7:0] a, b, r;
    a = rm[sa];
    b = op == 3'd6 ? imm : rm[sb];
    case (op)
      3'd0: r = 8'((a + b) % 256);
      3'd1: r = 8'((256 + a - b) % 256);
      3'd2: r = 8'((a * 2) % 256);
      3'd3: r = a / 2;
      3'd4: r = a;
      3'd6: r = imm;
      default: r = b;
    endcase
    chk("ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_op = op;
    in_dst = dst;
    in_srca = sa;
    in_srcb = sb;
    in_imm = imm;
    @(posedge clk);
    #1 scramble(hold);
    @(negedge clk);
    chk("issue_a", alu_a, a);
    chk("issue_b", alu_b, b);
    chk("issue_n", alu_n, op >= 3'd6 ? 3'd5 : op);
    chk("issue_ready", in_ready, 0);
    chk("issue_resv", res_valid, 0);
    dbg_sel = dst;
    @(negedge clk);
    chk("wb_ready", in_ready, 0);
    chk("wb_a", alu_a, a);
    chk("wb_b", alu_b, b);
    chk("wb_resv", res_valid, 0);
    @(negedge clk);
    if (op != 3'd7) begin
      rm[dst] = r;
      fm = cc_of(r, a, b);
      rdm = r;
      rdst = dst;
    end
    chk("res_valid", res_valid, op != 3'd7);
    chk("res_data", res_data, rdm);
    chk("res_dst", res_dst, rdst);
    chk("flags", flags, fm);
    chk("res_ready", in_ready, 1);
    chk("dbg_wb", dbg_data, rm[dst]);
    in_valid = 1'b0;
  endtask

  task automatic abort(input int when);
    in_valid = 1'b1;
    in_op = 3'd6;
    in_dst = 2'd1;
    in_srca = 2'd0;
    in_srcb = 2'd0;
    in_imm = 8'hAA;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (when) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_rst", in_ready, 0);
    chk("abort_resv", res_valid, 0);
    rst = 1'b0;
    model_reset();
    #1 chk("abort_ready", in_ready, 1);
    @(negedge clk);
    chk("abort_resv2", res_valid, 0);
    chk_regs();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_op = 3'd0;
    in_dst = 2'd0;
    in_srca = 2'd0;
    in_srcb = 2'd0;
    in_imm = 8'h00;
    dbg_sel = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    rst = 1'b0;
    #1 chk("rst_ready_after", in_ready, 1);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_n", alu_n, 0);
    chk("rst_resv", res_valid, 0);
    chk("rst_rdata", res_data, 0);
    chk("rst_rdst", res_dst, 0);
    chk("rst_flags", flags, 0);
    chk_regs();
    @(negedge clk);
    run(3'd6, 2'd0, 2'd0, 2'd0, 8'h12, 1'b0);
    run(3'd6, 2'd1, 2'd0, 2'd0, 8'h05, 1'b0);
    chk_regs();
    run(3'd6, 2'd0, 2'd3, 2'd2, 8'hFF, 1'b0);
    run(3'd6, 2'd1, 2'd0, 2'd0, 8'h01, 1'b0);
    run(3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0);
    chk("wrap_r2", rm[2] == 8'h00 && res_data == 8'h00, 1);
    run(3'd6, 2'd0, 2'd0, 2'd0, 8'h12, 1'b1);
    run(3'd6, 2'd1, 2'd0, 2'd0, 8'h05, 1'b1);
    run(3'd1, 2'd2, 2'd0, 2'd1, 8'h77, 1'b1);
    chk("sub_r2", dbg_data, 8'h0D);
    run(3'd2, 2'd3, 2'd2, 2'd0, 8'h00, 1'b1);
    chk("dbl_r3", dbg_data, 8'h1A);
    run(3'd7, 2'd1, 2'd2, 2'd3, 8'h99, 1'b0);
    chk_regs();
    run(3'd3, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0);
    chk("half_r0", dbg_data, 8'h09);
    run(3'd6, 2'd1, 2'd0, 2'd0, 8'h33, 1'b0);
    abort(1);
    run(3'd6, 2'd1, 2'd0, 2'd0, 8'h44, 1'b0);
    abort(2);
    for (int k = 0; k < 60; k++) begin
      run(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("idle_resv", res_valid, 0);
      end
    end
    chk_regs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Operand-issue and writeback stage directly upstream/downstream of the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from a local 4x8 register file.
- Drives the ALU's a/b/n inputs from registers, then captures the ALU result r and flags cc back into the register file and a flags register.
- The ALU is purely combinational; this block supplies all sequencing around it.

Parameters:
- REGS, 4, number of 8-bit registers (fixed at 4; selectors are 2 bits).
- W, 8, data width (matches ALU a/b/r).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept an instruction.
- in_op  in  3  opcode: 0 add, 1 sub, 2 A*2, 3 A/2, 4 pass A, 5 pass B, 6 load-immediate, 7 NOP.
- in_dst  in  2  destination register index.
- in_srca  in  2  register index for ALU operand a.
- in_srcb  in  2  register index for ALU operand b.
- in_imm  in  8  immediate; used only by op 6.
- alu_a  out  8  to ALU a.
- alu_b  out  8  to ALU b.
- alu_n  out  3  to ALU n.
- alu_r  in  8  from ALU r.
- alu_cc  in  4  from ALU cc.
- res_valid  out  1  one-cycle pulse when a result is written back.
- res_data  out  8  value written back; valid when res_valid=1.
- res_dst  out  2  register written; valid when res_valid=1.
- flags  out  4  last captured alu_cc.
- dbg_sel  in  2  debug read index.
- dbg_data  out  8  combinational read of reg[dbg_sel]; reflects a write on the cycle after it.

Behaviour:
- FSM states: IDLE -> ISSUE -> WB -> IDLE. No other transitions.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at edge T: latch op/dst/imm and read reg[srca], reg[srcb] into alu_a/alu_b; go to ISSUE.
  - in_valid=0: stay in IDLE.
- ISSUE (cycle T+1):
  - alu_a, alu_b, alu_n are stable registered values; ALU settles combinationally.
  - in_ready=0.
  - Go to WB unconditionally.
- Operand mapping:
  - Ops 0–5: alu_n=op, alu_a=reg[srca], alu_b=reg[srcb].
  - Op 6 (load-immediate): alu_n=5 (pass B), alu_b=in_imm, alu_a=reg[srca]. The result therefore flows through the ALU.
  - Op 7 (NOP): alu_n=5, alu_a/alu_b loaded as for ops 0–5; no writeback.
- WB (cycle T+2):
  - For ops 0–6: reg[dst]<=alu_r, flags<=alu_cc, res_data<=alu_r, res_dst<=dst; res_valid=1 for the following cycle (T+3) only.
  - For op 7: registers, flags and res_* are unchanged; res_valid stays 0.
  - Then return to IDLE.
- Timing:
  - res_valid is observed at T+3, coinciding with in_ready=1.
  - Throughput: one instruction per 3 cycles.
  - Latency from acceptance edge to res_valid: 3 cycles.
- Hazards:
  - None, because execution is strictly serial.
  - An instruction accepted at T+3 that reads the previous dst sees the written value.
  - srca==srcb==dst is legal; the old value is read and the new value is written.
- Arithmetic:
  - All results are whatever the ALU returns, truncated to 8 bits (e.g. 0xFF+0x01 -> 0x00).
  - This block does no arithmetic of its own.
  - alu_cc is captured verbatim, including X/unset bits; flags is not interpreted here.
- Handshake:
  - in_valid is ignored while in_ready=0; instruction inputs need not be held after acceptance.
  - in_valid held high continuously is accepted each time the block returns to IDLE.
- Reset (rst=1 at an edge):
  - Outputs: state=IDLE; all regs, alu_a, alu_b, res_data, res_dst, flags = 0; alu_n=0; res_valid=0.
  - in_ready=0 during any cycle rst is high; in_ready=1 on the first cycle after rst deasserts.
  - Reset during ISSUE or WB aborts the instruction: no register write and no res_valid pulse, even if rst coincides with the WB edge.

Test Plan:
- Reset, then load-immediates: op6 dst0 imm 0x12, then op6 dst1 imm 0x05 -> res_valid pulses with 0x12/dst0 then 0x05/dst1; dbg_sel=1 gives 0x05.
- Add with wrap: r0=0xFF, r1=0x01, op0 dst2 srca0 srcb1 -> at T+1 alu_a=0xFF, alu_b=0x01, alu_n=0; at T+3 res_data=0x00, res_dst=2, flags=alu_cc sampled at T+2.
- Back-to-back with in_valid held high: sub r2=r0-r1 (0x12-0x05) then A*2 r3=r2 -> in_ready high only in IDLE; r2=0x0D, then r3=0x1A; res_valid pulses exactly 3 cycles apart.
- NOP and self-update: op7 -> no res_valid, regs and flags unchanged; then op3 dst0 srca0 with r0=0x12 -> r0=0x09.
- Reset mid-operation: accept op6 dst1 imm 0xAA, assert rst in ISSUE cycle -> no res_valid pulse, r1=0x00, in_ready=1 on the first cycle after rst low.
- Ignored input: toggle in_valid with different instructions during ISSUE/WB -> only the originally accepted instruction executes; alu_* stay stable through ISSUE and WB.
